// File: rtl/ofm_drain_pkg.sv
// drain_pkg: shared types and constants for the systolic-column output drain.
package drain_pkg;
  localparam int OWIDTH_DEF = 24;
  localparam int CWIDTH_DEF = 8;
  localparam logic [CWIDTH_DEF-1:0] DRAIN_CNT_MAX = '1;
  typedef struct packed {
    logic signed [OWIDTH_DEF-1:0] data;
    logic [CWIDTH_DEF-1:0]        cnt;
  } drain_entry_t;
  typedef enum logic {S_IDLE, S_OPEN} drain_state_t;
endpackage

// File: rtl/ofm_drain_fifo.sv
// drain_fifo: synchronous FIFO with wrap-bit pointers; a push while full needs a same-cycle pop.
module drain_fifo
  import drain_pkg::*;
#(
  parameter int  DEPTH = 4,
  parameter type T     = drain_entry_t
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  T                         din,
  output T                         dout,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);
  localparam int AW = $clog2(DEPTH);
  T r_mem [DEPTH];
  logic [AW:0] r_wp, r_rp;
  logic w_push, w_pop;
  always_comb begin
    level  = r_wp - r_rp;
    empty  = r_wp == r_rp;
    full   = (r_wp[AW] != r_rp[AW]) && (r_wp[AW-1:0] == r_rp[AW-1:0]);
    w_pop  = pop & ~empty;
    w_push = push & (~full | w_pop);
    dout   = r_mem[r_rp[AW-1:0]];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wp <= '0;
      r_rp <= '0;
    end else begin
      if (w_push) r_wp <= r_wp + 1'b1;
      if (w_pop) r_rp <= r_rp + 1'b1;
    end
  end
  always_ff @(posedge clk)
    if (w_push) r_mem[r_wp[AW-1:0]] <= din;
endmodule

// File: rtl/ofm_drain.sv
// ofm_drain: detects accumulation-window ends on the bottom-PE stream and queues {final sum, beat count}.
module ofm_drain
  import drain_pkg::*;
#(
  parameter int OWIDTH = 24,
  parameter int CWIDTH = 8,
  parameter int FDEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       en_o,
  input  logic                       clr_o,
  input  logic signed [OWIDTH-1:0]   ofm,
  output logic                       o_valid,
  input  logic                       o_ready,
  output logic signed [OWIDTH-1:0]   o_data,
  output logic [CWIDTH-1:0]          o_cnt,
  output logic [$clog2(FDEPTH):0]    o_level,
  output logic                       err_ovf
);
  typedef struct packed {
    logic signed [OWIDTH-1:0] data;
    logic [CWIDTH-1:0]        cnt;
  } entry_t;
  drain_state_t r_state, w_state_n;
  logic signed [OWIDTH-1:0] r_held, w_held_n;
  logic [CWIDTH-1:0] r_cnt, w_cnt_n;
  logic r_err, w_err_n, w_start, w_end, w_pop, w_full, w_empty;
  entry_t w_head, w_push_data;
  // A clr_o beat closes the open window and starts the next one in the same cycle.
  always_comb begin
    w_start     = en_o & ((r_state == S_IDLE) | clr_o);
    w_end       = (r_state == S_OPEN) & (~en_o | clr_o);
    w_pop       = ~w_empty & o_ready;
    w_state_n   = en_o ? S_OPEN : S_IDLE;
    w_held_n    = en_o ? ofm : r_held;
    w_cnt_n     = w_start ? CWIDTH'(1) : (en_o & ~&r_cnt) ? r_cnt + 1'b1 : r_cnt;
    w_err_n     = r_err | (w_end & w_full & ~w_pop);
    w_push_data = '{data: r_held, cnt: r_cnt};
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
      r_held  <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_held  <= w_held_n;
      r_cnt   <= w_cnt_n;
      r_err   <= w_err_n;
    end
  end
  drain_fifo #(.DEPTH(FDEPTH), .T(entry_t)) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_end),
    .pop   (w_pop),
    .din   (w_push_data),
    .dout  (w_head),
    .full  (w_full),
    .empty (w_empty),
    .level (o_level)
  );
  assign o_valid = ~w_empty;
  assign o_data  = o_valid ? w_head.data : '0;
  assign o_cnt   = o_valid ? w_head.cnt : '0;
  assign err_ovf = r_err;
endmodule

// File: tb/tb_ofm_drain.sv
// tb_ofm_drain: directed and randomized stimulus against a queue-based window model.
module tb_ofm_drain;
  logic clk = 0, rst = 1, en_o = 0, clr_o = 0, o_ready = 0;
  logic signed [23:0] ofm = '0;
  logic o_valid, err_ovf;
  logic signed [23:0] o_data;
  logic [7:0] o_cnt;
  logic [2:0] o_level;
  int errors = 0, checks = 0;
  bit armed = 0;

  ofm_drain #(.OWIDTH(24), .CWIDTH(8), .FDEPTH(4)) dut (
    .clk(clk), .rst(rst), .en_o(en_o), .clr_o(clr_o), .ofm(ofm),
    .o_valid(o_valid), .o_ready(o_ready), .o_data(o_data), .o_cnt(o_cnt),
    .o_level(o_level), .err_ovf(err_ovf)
  );

  always #5 clk = ~clk;

  typedef struct { int d; int c; } ent_t;
  ent_t q[$];
  bit m_open = 0, m_err = 0;
  int m_held = 0, m_cnt = 0;

  // Model: windows as a list of completed entries, bounded to four slots.
  always @(posedge clk) begin
    if (rst) begin
      q.delete(); m_open = 0; m_err = 0; m_held = 0; m_cnt = 0;
    end else begin
      bit ending;
      ending = m_open && (!en_o || clr_o);
      if (q.size() > 0 && o_ready) void'(q.pop_front());
      if (ending) begin
        if (q.size() < 4) q.push_back('{m_held, m_cnt});
        else m_err = 1;
      end
      if (en_o) begin
        m_cnt = (!m_open || clr_o) ? 1 : (m_cnt < 255 ? m_cnt + 1 : 255);
        m_held = int'(ofm);
        m_open = 1;
      end else m_open = 0;
    end
  end

  task automatic cmp(string name, int act, int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (armed) begin
    int ev, ed, ec;
    ev = q.size() > 0;
    ed = ev ? q[0].d : 0;
    ec = ev ? q[0].c : 0;
    cmp("valid", int'(o_valid), ev);
    cmp("data", int'(o_data), ed);
    cmp("cnt", int'(o_cnt), ec);
    cmp("level", int'(o_level), q.size());
    cmp("err_ovf", int'(err_ovf), int'(m_err));
  end

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic beat(int v, bit c);
    en_o = 1; clr_o = c; ofm = 24'(v); step();
  endtask

  task automatic idle();
    en_o = 0; clr_o = 0; step();
  endtask

  task automatic drain();
    o_ready = 1; repeat (5) idle(); o_ready = 0;
  endtask

  task automatic zeros(string tag);
    cmp({tag, "_valid"}, int'(o_valid), 0);
    cmp({tag, "_data"}, int'(o_data), 0);
    cmp({tag, "_cnt"}, int'(o_cnt), 0);
    cmp({tag, "_level"}, int'(o_level), 0);
    cmp({tag, "_err"}, int'(err_ovf), 0);
  endtask

  initial begin
    step(); rst = 0; armed = 1;
    zeros("reset");
    beat(5, 1); beat(12, 0); beat(-7, 0);
    cmp("single_pre_valid", int'(o_valid), 0);
    idle();
    cmp("single_data", int'(o_data), -7);
    cmp("single_cnt", int'(o_cnt), 3);
    drain();
    beat(3, 1); beat(9, 0); beat(100, 1); beat(4, 0); idle();
    cmp("b2b_level", int'(o_level), 2);
    cmp("b2b_data0", int'(o_data), 9);
    cmp("b2b_cnt0", int'(o_cnt), 2);
    o_ready = 1; idle(); o_ready = 0;
    cmp("b2b_data1", int'(o_data), 4);
    cmp("b2b_cnt1", int'(o_cnt), 2);
    drain();
    for (int i = 1; i <= 5; i++) beat(i, 1);
    idle();
    cmp("ovf_level", int'(o_level), 4);
    cmp("ovf_err", int'(err_ovf), 1);
    o_ready = 1;
    for (int i = 1; i <= 4; i++) begin
      cmp("ovf_drain", int'(o_data), i);
      idle();
    end
    cmp("ovf_empty", int'(o_valid), 0);
    o_ready = 0;
    rst = 1; step(); rst = 0;
    zeros("rst2");
    for (int i = 11; i <= 15; i++) beat(i, 1);
    cmp("full_level", int'(o_level), 4);
    o_ready = 1; idle(); o_ready = 0;
    cmp("fullpop_level", int'(o_level), 4);
    cmp("fullpop_err", int'(err_ovf), 0);
    cmp("fullpop_head", int'(o_data), 12);
    drain();
    beat(7, 1); beat(8, 0);
    en_o = 0; rst = 1; step(); rst = 0;
    zeros("midrst");
    beat(2, 1); idle();
    cmp("midrst_data", int'(o_data), 2);
    cmp("midrst_cnt", int'(o_cnt), 1);
    cmp("midrst_level", int'(o_level), 1);
    drain();
    beat(-1000, 1);
    for (int i = 1; i < 300; i++) beat(i, 0);
    idle();
    cmp("sat_cnt", int'(o_cnt), 255);
    cmp("sat_data", int'(o_data), 299);
    drain();
    for (int w = 0; w < 50; w++) begin
      int len;
      len = $urandom_range(1, 6);
      for (int b = 0; b < len; b++) begin
        o_ready = 1'($urandom_range(0, 1));
        beat(int'($urandom) - 32'h8000_0000 >>> 8, b == 0);
      end
      if ($urandom_range(0, 2) == 0) begin
        o_ready = 1'($urandom_range(0, 1));
        idle();
      end
    end
    drain();
    cmp("final_level", int'(o_level), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
